// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: iterative BCD-to-binary converter (reverse double-dabble), optional input digit check under BCD_CHECK_EN
module bcd_to_bin_seq #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int W  = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state;
  logic [W-1:0]    sr, s, t;
  logic [CW-1:0]   cnt;
  assign s = sr >> 1;
  assign t[BIN_W-1:0] = s[BIN_W-1:0];
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign t[BIN_W+4*d +: 4] = s[BIN_W+4*d+3] ? s[BIN_W+4*d +: 4] - 4'd3 : s[BIN_W+4*d +: 4];
  end
`ifdef BCD_CHECK_EN
  logic                bad;
  logic [DIGITS-1:0]   dig_bad;
  for (genvar d = 0; d < DIGITS; d++) begin : g_chk
    assign dig_bad[d] = bcd_in[4*d +: 4] > 4'd9;
  end
`else
  assign err = 1'b0;
`endif
  // FSM: load on accepted start, shift-and-correct BIN_W times, then publish result with a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      sr      <= '0;
      cnt     <= '0;
`ifdef BCD_CHECK_EN
      err     <= 1'b0;
      bad     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sr    <= {bcd_in, {BIN_W{1'b0}}};
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
`ifdef BCD_CHECK_EN
          bad   <= |dig_bad;
`endif
        end
      end else begin
        sr  <= t;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(BIN_W - 1)) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef BCD_CHECK_EN
          bin_out <= bad ? '0 : t[BIN_W-1:0];
          err     <= bad;
`else
          bin_out <= t[BIN_W-1:0];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and random checks of the sequential BCD-to-binary converter
module tb_bcd_to_bin_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] bcd_in = '0;
  logic        busy, done, err;
  logic [19:0] bin_out;
  int          total = 0;
  int          bad = 0;

  bcd_to_bin_seq #(.DIGITS(6), .BIN_W(20)) dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic conv(input string tag, input logic [23:0] b, input logic [19:0] exp, input logic exp_err);
    int k, nb;
    @(negedge clk);
    bcd_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd_in = 24'($urandom);
    k = 1;
    nb = 0;
    while (!done && k < 100) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".lat"}, 32'(k - 1), 32'd20);
    chk({tag, ".busy_cycles"}, 32'(nb), 32'd20);
    chk({tag, ".bin"}, 32'(bin_out), 32'(exp));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, ".done_width"}, 32'(done), 32'd0);
    chk({tag, ".hold"}, 32'(bin_out), 32'(exp));
  endtask

  initial begin
    int k, seen;
    logic [23:0] b;
    logic [19:0] v;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.bin", 32'(bin_out), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(busy), 32'd0);
    conv("zero", 24'h000000, 20'h00000, 1'b0);
    conv("c131071", 24'h131071, 20'h1FFFF, 1'b0);
    conv("c999999", 24'h999999, 20'hF423F, 1'b0);
    @(negedge clk);
    bcd_in = 24'h000042;
    start = 1'b1;
    @(negedge clk);
    bcd_in = 24'h000099;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bb1.lat", 32'(k), 32'd21);
    chk("bb1.bin", 32'(bin_out), 32'h2A);
    k = 0;
    @(negedge clk);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("bb2.period", 32'(k), 32'd21);
    chk("bb2.bin", 32'(bin_out), 32'h63);
    repeat (3) @(negedge clk);
    chk("bb.idle", 32'(busy), 32'd0);
    @(negedge clk);
    bcd_in = 24'h123456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ab.busy_before", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ab.busy", 32'(busy), 32'd0);
    chk("ab.done", 32'(done), 32'd0);
    chk("ab.bin", 32'(bin_out), 32'd0);
    chk("ab.err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("ab.no_done", 32'(seen), 32'd0);
    conv("c123456", 24'h123456, 20'h1E240, 1'b0);
`ifdef BCD_CHECK_EN
    conv("badA", 24'h12A456, 20'h00000, 1'b1);
    conv("c10", 24'h000010, 20'h0000A, 1'b0);
`endif
    for (int n = 0; n < 1000; n++) begin
      v = '0;
      for (int i = 5; i >= 0; i--) begin
        b[4*i +: 4] = 4'($urandom_range(9));
        v = 20'(v * 10 + 20'(b[4*i +: 4]));
      end
      conv("rand", b, v, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
